// File: rtl/ifu_fetch_if.sv
// Fetch unit bus: memory request/response plus redirect and decode handshake.
// master is the fetch unit, slave is the memory/decode/redirect environment.
interface ifu_fetch_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int TAG_WIDTH  = 2
);
  logic                  flush_in;
  logic [ADDR_WIDTH-1:0] flush_pc;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic                  mem_rvalid_in;
  logic [TAG_WIDTH-1:0]  mem_rtag_in;
  logic [31:0]           mem_rdata;
  logic                  mem_rvalid_out;
  logic [TAG_WIDTH-1:0]  mem_rtag_out;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [31:0]           dec_instr;
  logic [ADDR_WIDTH-1:0] dec_pc;

  modport master (
    input  flush_in,
    input  flush_pc,
    output mem_raddr,
    output mem_rvalid_in,
    output mem_rtag_in,
    input  mem_rdata,
    input  mem_rvalid_out,
    input  mem_rtag_out,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc
  );

  modport slave (
    output flush_in,
    output flush_pc,
    input  mem_raddr,
    input  mem_rvalid_in,
    input  mem_rtag_in,
    output mem_rdata,
    output mem_rvalid_out,
    output mem_rtag_out,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch front-end: epoch-tagged sequential fetch from a
// 1-cycle instruction memory into a small buffer feeding decode.
module ifu_fetch #(
  parameter int          ADDR_WIDTH = 12,
  parameter int unsigned RESET_PC   = 0,
  parameter int          TAG_WIDTH  = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  ifu_fetch_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
  } ent_t;

  ent_t                  buf_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_q;
  logic [PW-1:0]         wr_q;
  logic [PW:0]           cnt_q;
  logic [PW:0]           cnt_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pend_q;
  logic [TAG_WIDTH-1:0]  ep_q;
  logic                  infl_q;
  logic [PW+1:0]         used;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  vld;

  // Credit counts the in-flight request but not a same-cycle pop.
  assign used  = {1'b0, cnt_q} + {{(PW+1){1'b0}}, infl_q};
  assign issue = !rst && !bus.flush_in
              && (used < (PW+2)'(FIFO_DEPTH));
  assign push  = bus.mem_rvalid_out
              && (bus.mem_rtag_out == ep_q)
              && !bus.flush_in;
  assign vld   = (cnt_q != '0);
  assign pop   = vld && bus.dec_ready;

  assign bus.mem_raddr     = pc_q;
  assign bus.mem_rvalid_in = issue;
  assign bus.mem_rtag_in   = ep_q;
  assign bus.dec_valid     = vld;
  assign bus.dec_instr     = buf_q[rd_q].instr;
  assign bus.dec_pc        = buf_q[rd_q].pc;

  always_comb begin
    pc_d = pc_q;
    if (bus.flush_in) begin
      pc_d = bus.flush_pc & ~ADDR_WIDTH'(3);
    end else if (issue) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + (PW+1)'(1);
      pop && !push: cnt_d = cnt_q - (PW+1)'(1);
      default:      cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= ADDR_WIDTH'(RESET_PC);
      pend_q <= '0;
      ep_q   <= '0;
      infl_q <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (bus.flush_in) begin
      pc_q   <= pc_d;
      ep_q   <= ep_q + TAG_WIDTH'(1);
      infl_q <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      infl_q <= issue;
      cnt_q  <= cnt_d;
      if (issue) begin
        pend_q <= pc_q;
      end
      if (push) begin
        buf_q[wr_q] <= '{pc: pend_q, instr: bus.mem_rdata};
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && cnt_q == (PW+1)'(FIFO_DEPTH))
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch against a queue-based reference model,
// plus a second instance checking address wrap from RESET_PC=0xFFC.
module tb_ifu_fetch;

  localparam int AW = 12;
  localparam int TW = 2;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_fetch_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) b0 ();
  ifu_fetch_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) b1 ();

  ifu_fetch #(
    .ADDR_WIDTH(AW), .RESET_PC(0),
    .TAG_WIDTH(TW), .FIFO_DEPTH(D)
  ) u0 (.clk(clk), .rst(rst), .bus(b0));

  ifu_fetch #(
    .ADDR_WIDTH(AW), .RESET_PC(32'hFFC),
    .TAG_WIDTH(TW), .FIFO_DEPTH(D)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  function automatic logic [31:0] word(logic [AW-1:0] a);
    return {8'hC3, 4'h5, a, ~a[7:0]};
  endfunction

  // Instruction memory: one-cycle latency, tag echoed back
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b0.mem_rvalid_out <= 1'b0;
      b0.mem_rdata      <= '0;
      b0.mem_rtag_out   <= '0;
      b1.mem_rvalid_out <= 1'b0;
      b1.mem_rdata      <= '0;
      b1.mem_rtag_out   <= '0;
    end else begin
      b0.mem_rvalid_out <= b0.mem_rvalid_in;
      b0.mem_rdata      <= word(b0.mem_raddr);
      b0.mem_rtag_out   <= b0.mem_rtag_in;
      b1.mem_rvalid_out <= b1.mem_rvalid_in;
      b1.mem_rdata      <= word(b1.mem_raddr);
      b1.mem_rtag_out   <= b1.mem_rtag_in;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: buffer as a queue of PCs, the rest as plain counters
  int unsigned   mq[$];
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_pend;
  int unsigned   m_ep;
  bit            m_infl;
  logic [AW-1:0] s_next;
  int            n_iss;

  bit            col1;
  int unsigned   r1[$];
  int unsigned   p1[$];

  task automatic model_reset();
    mq.delete();
    m_pc   = '0;
    m_pend = '0;
    m_ep   = 0;
    m_infl = 1'b0;
    s_next = '0;
  endtask

  task automatic cycle(bit fl, logic [AW-1:0] fpc, bit rdy);
    bit exp_iss;
    bit pop;
    bit push;
    b0.flush_in  = fl;
    b0.flush_pc  = fpc;
    b0.dec_ready = rdy;
    #2;
    exp_iss = !fl && ((mq.size() + int'(m_infl)) < D);
    chk("rvalid_in", b0.mem_rvalid_in, exp_iss);
    chk("raddr", b0.mem_raddr, m_pc);
    chk("rtag", b0.mem_rtag_in, m_ep % 4);
    chk("dec_valid", b0.dec_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("dec_pc", b0.dec_pc, mq[0]);
      chk("dec_instr", b0.dec_instr, word(mq[0][AW-1:0]));
    end
    pop = (mq.size() != 0) && rdy;
    if (pop) begin
      chk("stream_pc", b0.dec_pc, s_next);
      s_next = s_next + AW'(4);
    end
    if (b0.mem_rvalid_in) n_iss++;
    if (col1) begin
      if (b1.mem_rvalid_in) r1.push_back(b1.mem_raddr);
      if (b1.dec_valid && b1.dec_ready) p1.push_back(b1.dec_pc);
    end
    @(posedge clk);
    push = m_infl && !fl;
    if (fl) begin
      mq.delete();
      m_pc   = fpc & ~AW'(3);
      s_next = fpc & ~AW'(3);
      m_ep++;
      m_infl = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(m_pend);
      if (exp_iss) begin
        m_pend = m_pc;
        m_pc   = m_pc + AW'(4);
      end
      m_infl = exp_iss;
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(string pfx);
    chk({pfx, "_rvalid_in"}, b0.mem_rvalid_in, 0);
    chk({pfx, "_raddr"}, b0.mem_raddr, 0);
    chk({pfx, "_rtag"}, b0.mem_rtag_in, 0);
    chk({pfx, "_dec_valid"}, b0.dec_valid, 0);
    chk({pfx, "_dec_instr"}, b0.dec_instr, 0);
    chk({pfx, "_dec_pc"}, b0.dec_pc, 0);
    chk({pfx, "_u1_raddr"}, b1.mem_raddr, 'hFFC);
  endtask

  initial begin
    int unsigned wexp[3];
    wexp[0] = 'hFFC;
    wexp[1] = 'h000;
    wexp[2] = 'h004;
    rst = 1'b1;
    col1 = 1'b0;
    n_iss = 0;
    b0.flush_in = 1'b0;
    b0.flush_pc = '0;
    b0.dec_ready = 1'b1;
    b1.flush_in = 1'b0;
    b1.flush_pc = '0;
    b1.dec_ready = 1'b1;
    model_reset();
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b0;
    col1 = 1'b1;

    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);
    col1 = 1'b0;
    chk("u1_nreq", r1.size() >= 3, 1);
    chk("u1_npop", p1.size() >= 3, 1);
    for (int i = 0; i < 3; i++) begin
      if (i < r1.size()) chk("u1_raddr_seq", r1[i], wexp[i]);
      if (i < p1.size()) chk("u1_dec_pc_seq", p1[i], wexp[i]);
    end

    cycle(1'b1, 12'h102, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

    cycle(1'b1, 12'h200, 1'b1);
    n_iss = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0);
    chk("stall_issues", n_iss, D);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);

    cycle(1'b1, 12'h040, 1'b1);
    cycle(1'b1, 12'h080, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 15) == 0,
            AW'($urandom),
            $urandom_range(0, 9) < 7);
    end

    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch front-end that sits directly upstream of the instruction closely coupled memory.
- Generates sequential 4-byte fetch addresses and issues pipelined requests, each tagged with a redirect epoch.
- Captures the 1-cycle-latency responses into a small instruction buffer and presents {pc, instr} to decode over a valid/ready handshake.
- Handles pipeline redirects (branch/exception flush) by discarding stale in-flight responses.

Parameters:
- ADDR_WIDTH, 12, byte-address width of the instruction memory.
- RESET_PC, 0, first fetch address after reset; bits [1:0] must be 0.
- TAG_WIDTH, INSTR_MEM_TAG_WIDTH, epoch tag width sent with each request.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush_in  in  1  redirect request
- flush_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored, treated as 00
- mem_raddr  out  ADDR_WIDTH  fetch byte address to instruction memory
- mem_rvalid_in  out  1  fetch request valid
- mem_rtag_in  out  TAG_WIDTH  request tag (current epoch)
- mem_rdata  in  32  fetched instruction word
- mem_rvalid_out  in  1  response valid; arrives exactly 1 cycle after the request
- mem_rtag_out  in  TAG_WIDTH  response tag
- dec_valid  out  1  buffer head valid
- dec_ready  in  1  decode accepts the head
- dec_instr  out  32  head instruction
- dec_pc  out  ADDR_WIDTH  head instruction address

Behaviour:
- Reset (async assert, synchronous-clock deassert):
  - pc = RESET_PC, epoch = 0, buffer empty, no request in flight.
  - Outputs: mem_rvalid_in = 0, mem_raddr = RESET_PC, mem_rtag_in = 0, dec_valid = 0, dec_instr = 0, dec_pc = 0.
- Issue:
  - mem_rvalid_in = !flush_in && (count + inflight < FIFO_DEPTH).
  - inflight = 1 if a request was issued in the previous cycle.
  - A same-cycle pop does not count toward credit; this is deliberately conservative and guarantees no overflow.
- mem_raddr and mem_rtag_in:
  - mem_raddr always equals the registered pc; mem_rtag_in equals the registered epoch.
  - On issue, pc <= pc + 4, wrapping modulo 2^ADDR_WIDTH.
  - mem_raddr[1:0] is always 00, so the address low bits are stable during the response cycle.
- Pending PC: on issue, the issued address is registered as pend_pc, paired with the response one cycle later.
- Capture: when mem_rvalid_out && mem_rtag_out == epoch && !flush_in, push {pend_pc, mem_rdata}. Otherwise the response is dropped.
- Decode handshake:
  - Head pops when dec_valid && dec_ready.
  - dec_valid = (count != 0).
  - dec_instr and dec_pc come from the buffer head and hold stable while valid && !ready.
  - Push and pop in the same cycle: count unchanged, both take effect. Pushing into a full buffer cannot occur by construction; assertion-check it.
  - When empty, dec_instr and dec_pc show the stale head entry and are don't-care.
- Flush (flush_in = 1 in cycle T):
  - Buffer cleared in T, pc <= {flush_pc[ADDR_WIDTH-1:2], 2'b00}, epoch <= epoch + 1 (wraps), no issue in T, dec_valid = 0 from T+1.
  - Response arriving in T or T+1 carries the old epoch and is dropped.
  - First new request issues in T+1; its response is pushed in T+2; dec_valid = 1 in T+3.
  - Flush wins over a simultaneous pop; the popped entry counts as consumed by decode.
  - Back-to-back flushes: the last target wins, and epoch increments each cycle.
- Epoch wrap: TAG_WIDTH >= 1 suffices because at most one stale response is in flight.
- Steady state with dec_ready = 1: one instruction per cycle.

Test Plan:
- Reset release with RESET_PC=0x000, dec_ready=1 -> requests at 0x000, 0x004, 0x008 in consecutive cycles; dec_valid first asserted 2 cycles after the first request; dec_pc sequence 0x000, 0x004, 0x008 with matching preloaded words.
- dec_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 requests issued, then mem_rvalid_in=0; head holds {0x000, word0}; releasing ready drains 4 entries and issue resumes at 0x010 with no gaps or duplicates.
- flush_in for 1 cycle with flush_pc=0x102 during streaming -> buffer empties; the in-flight response is dropped (old tag); next request at 0x100 with tag incremented; dec_pc=0x100 appears 3 cycles after the flush.
- Flush in two consecutive cycles (0x040, then 0x080) -> only 0x080 is fetched; epoch advanced by 2; no 0x040 instruction reaches decode.
- PC wrap with RESET_PC=0xFFC -> requests 0xFFC, 0x000; dec_pc follows the same sequence.
- rst asserted mid-stream between clock edges -> all outputs reset immediately (async); after release, fetch restarts at RESET_PC with epoch 0.
